vec_subtracter: RTL and testbench

VEC_SUBTRACTER -- requirements
Module: vec_subtracter

---
 rtl/vec_subtracter.sv | 154 +++++++++++++++
 tb/tb_vec_subtracter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_subtracter.sv
// vec_subtracter
//   Multi-lane signed subtracter with a valid/ready pipeline of STAGES
//   register stages. All arithmetic happens in the first stage at DATA_W+1
//   bits; later stages only carry the result and saturation flags forward.
//
// Ports
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   in_valid   : input beat present
//   in_ready   : input beat accepted this cycle (0 while rst=1)
//   in_mode    : 00 a-b wrap, 01 a-b saturate, 10 |a-b|, 11 b-a
//   data_a     : packed signed minuends, lane l at [l*DATA_W +: DATA_W]
//   data_b     : packed signed subtrahends, same packing
//   out_valid  : result beat present
//   out_ready  : downstream accepts result beat
//   result     : packed per-lane results, lane l at [l*(DATA_W+1) +: DATA_W+1]
//   sat_flag   : per-lane clamp indication (mode 01 only)
//   beat_cnt   : number of delivered result beats, wraps at 16 bits
module vec_subtracter #(
    parameter int DATA_W = 8,
    parameter int LANES  = 4,
    parameter int STAGES = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [1:0]                    in_mode,
    input  logic [LANES*DATA_W-1:0]       data_a,
    input  logic [LANES*DATA_W-1:0]       data_b,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [LANES*(DATA_W+1)-1:0]   result,
    output logic [LANES-1:0]              sat_flag,
    output logic [15:0]                   beat_cnt
);

    localparam int RW = DATA_W + 1;
    localparam int VW = LANES * RW;

    localparam logic signed [DATA_W:0] SAT_MAX = {2'b00, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W:0] SAT_MIN = {2'b11, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        MODE_WRAP = 2'b00,
        MODE_SAT  = 2'b01,
        MODE_ABS  = 2'b10,
        MODE_REV  = 2'b11
    } mode_e;

    logic [STAGES-1:0]  valid_q;
    logic [STAGES-1:0]  load;
    logic [VW-1:0]      res_q [STAGES];
    logic [LANES-1:0]   sat_q [STAGES];
    logic [15:0]        cnt_q;

    logic [VW-1:0]      res_d;
    logic [LANES-1:0]   sat_d;
    logic               accept;
    logic               all_full;

    logic signed [DATA_W:0] a_x;
    logic signed [DATA_W:0] b_x;
    logic signed [DATA_W:0] diff;
    logic signed [DATA_W:0] lane_r;

    // Stage k may load iff some stage at or after k has a free slot, or the
    // output drains this cycle. Flattened from the recursive form
    // load[k] = !valid[k] | load[k+1] to avoid a self-referencing vector.
    always_comb begin
        load     = '0;
        all_full = 1'b1;
        for (int unsigned k = 0; k < STAGES; k++) begin
            all_full = 1'b1;
            for (int unsigned j = k; j < STAGES; j++) begin
                all_full = all_full & valid_q[j];
            end
            load[k] = ~all_full | out_ready;
        end
    end

    assign in_ready = load[0] & ~rst;
    assign accept   = in_valid & in_ready;

    // Per-lane arithmetic at DATA_W+1 bits after sign extension.
    always_comb begin
        res_d  = '0;
        sat_d  = '0;
        a_x    = '0;
        b_x    = '0;
        diff   = '0;
        lane_r = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            a_x  = {data_a[l*DATA_W + DATA_W - 1], data_a[l*DATA_W +: DATA_W]};
            b_x  = {data_b[l*DATA_W + DATA_W - 1], data_b[l*DATA_W +: DATA_W]};
            diff = a_x - b_x;
            case (mode_e'(in_mode))
                MODE_WRAP: lane_r = diff;
                MODE_SAT: begin
                    // Top two bits differ exactly when a-b leaves DATA_W range.
                    if (diff[DATA_W] != diff[DATA_W-1]) begin
                        lane_r   = diff[DATA_W] ? SAT_MIN : SAT_MAX;
                        sat_d[l] = 1'b1;
                    end else begin
                        lane_r = diff;
                    end
                end
                MODE_ABS:  lane_r = diff[DATA_W] ? -diff : diff;
                MODE_REV:  lane_r = b_x - a_x;
                default:   lane_r = diff;
            endcase
            res_d[l*RW +: RW] = lane_r;
        end
    end

    // Data registers only capture when a valid beat moves in, so the output
    // holds its last delivered value while out_valid is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            cnt_q   <= '0;
            for (int unsigned k = 0; k < STAGES; k++) begin
                res_q[k] <= '0;
                sat_q[k] <= '0;
            end
        end else begin
            if (load[0]) begin
                valid_q[0] <= accept;
            end
            if (accept) begin
                res_q[0] <= res_d;
                sat_q[0] <= sat_d;
            end
            for (int unsigned k = 1; k < STAGES; k++) begin
                if (load[k]) begin
                    valid_q[k] <= valid_q[k-1];
                end
                if (load[k] && valid_q[k-1]) begin
                    res_q[k] <= res_q[k-1];
                    sat_q[k] <= sat_q[k-1];
                end
            end
            if (valid_q[STAGES-1] && out_ready) begin
                cnt_q <= cnt_q + 16'd1;
            end
        end
    end

    assign out_valid = valid_q[STAGES-1];
    assign result    = res_q[STAGES-1];
    assign sat_flag  = sat_q[STAGES-1];
    assign beat_cnt  = cnt_q;

endmodule

// File: tb/tb_vec_subtracter.sv
// tb_vec_subtracter
//   Self-checking bench for vec_subtracter (DATA_W=8, LANES=2, STAGES=2).
//   Expected beats come from an integer-arithmetic model and are kept in an
//   in-order queue; directed cases use literal expected values.
module tb_vec_subtracter;

    localparam int DW = 8;
    localparam int L  = 2;
    localparam int ST = 2;
    localparam int RW = DW + 1;
    localparam int MAXV = (2 ** (DW - 1)) - 1;
    localparam int MINV = -(2 ** (DW - 1));

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic [1:0]           in_mode;
    logic [L*DW-1:0]      data_a;
    logic [L*DW-1:0]      data_b;
    logic                 out_valid;
    logic                 out_ready;
    logic [L*RW-1:0]      result;
    logic [L-1:0]         sat_flag;
    logic [15:0]          beat_cnt;

    typedef struct packed {
        logic [L*RW-1:0] res;
        logic [L-1:0]    sat;
    } exp_t;

    exp_t            q[$];
    int              n_tests = 0;
    int              n_fail  = 0;
    int              ta[L];
    int              tbv[L];
    logic [1:0]      tmode;
    int              delivered = 0;
    logic [15:0]     tb_cnt = '0;
    logic [L*RW-1:0] last_res = '0;
    logic [L-1:0]    last_sat = '0;
    bit              acc;

    vec_subtracter #(.DATA_W(DW), .LANES(L), .STAGES(ST)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_mode(in_mode), .data_a(data_a), .data_b(data_b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .sat_flag(sat_flag), .beat_cnt(beat_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [1:0] m);
        exp_t        e;
        int          d;
        int          r;
        logic [31:0] rv;
        e = '0;
        for (int l = 0; l < L; l++) begin
            d = ta[l] - tbv[l];
            r = d;
            case (m)
                2'b00: r = d;
                2'b01: begin
                    if (d > MAXV) begin r = MAXV; e.sat[l] = 1'b1; end
                    else if (d < MINV) begin r = MINV; e.sat[l] = 1'b1; end
                    else r = d;
                end
                2'b10: r = (d < 0) ? -d : d;
                default: r = tbv[l] - ta[l];
            endcase
            rv = r;
            e.res[l*RW +: RW] = rv[RW-1:0];
        end
        return e;
    endfunction

    function automatic int rnd_op();
        case ($urandom_range(3))
            0: return MINV;
            1: return MAXV;
            default: return int'($urandom_range(255)) - 128;
        endcase
    endfunction

    task automatic randomize_beat();
        for (int l = 0; l < L; l++) begin
            ta[l]  = rnd_op();
            tbv[l] = rnd_op();
        end
        tmode = 2'($urandom_range(3));
    endtask

    task automatic apply();
        logic [31:0] av;
        logic [31:0] bv;
        for (int l = 0; l < L; l++) begin
            av = ta[l];
            bv = tbv[l];
            data_a[l*DW +: DW] = av[DW-1:0];
            data_b[l*DW +: DW] = bv[DW-1:0];
        end
        in_mode = tmode;
    endtask

    // Called at a falling edge with inputs chosen; samples just after,
    // scores what the next rising edge will transfer, then waits a cycle.
    task automatic step();
        exp_t e;
        apply();
        #1;
        if (out_valid && out_ready) begin
            check("beat_cnt", beat_cnt, tb_cnt);
            check("beat_expected", q.size() > 0, 1);
            if (q.size() > 0) begin
                e = q.pop_front();
                check("result", result, e.res);
                check("sat_flag", sat_flag, e.sat);
            end
            last_res = result;
            last_sat = sat_flag;
            tb_cnt++;
            delivered++;
        end else if (!out_valid) begin
            check("hold_result", result, last_res);
            check("hold_sat", sat_flag, last_sat);
        end
        acc = in_valid && in_ready;
        if (acc) q.push_back(model(tmode));
        @(negedge clk);
    endtask

    task automatic directed(input string tag, input logic [1:0] m,
                            input int a0, input int a1, input int b0, input int b1,
                            input logic [L*RW-1:0] er, input logic [L-1:0] es);
        int lat;
        int d0;
        ta[0] = a0; ta[1] = a1; tbv[0] = b0; tbv[1] = b1; tmode = m;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        step();
        check({tag, "_accept"}, acc, 1);
        in_valid = 1'b0;
        d0  = delivered;
        lat = 0;
        while (delivered == d0 && lat < 10) begin
            step();
            lat++;
        end
        check({tag, "_latency"}, lat, ST);
        check({tag, "_res"}, last_res, er);
        check({tag, "_sat"}, last_sat, es);
    endtask

    initial begin
        int  sent;
        int  cyc;
        int  d0;
        bit  need_new;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; tmode = 2'b00;
        for (int l = 0; l < L; l++) begin ta[l] = 0; tbv[l] = 0; end
        apply();
        repeat (3) @(negedge clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_sat", sat_flag, 0);
        check("rst_beat_cnt", beat_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("in_ready_after_rst", in_ready, 1);
        @(negedge clk);

        directed("wrap",  2'b00, 127, -128, -128, 127, {9'h101, 9'h0FF}, 2'b00);
        directed("sat",   2'b01, 127, -128, -128, 127, {9'h180, 9'h07F}, 2'b11);
        directed("sat_in", 2'b01, 5, -3, 7, -3,        {9'h000, 9'h1FE}, 2'b00);
        directed("abs",   2'b10, -128, 10, 127, 20,    {9'h00A, 9'h0FF}, 2'b00);
        directed("rev",   2'b11, -128, 10, 127, 20,    {9'h00A, 9'h0FF}, 2'b00);

        // Backpressure: out_ready follows 1,0,0 repeating.
        sent = 0; cyc = 0; d0 = delivered; need_new = 1'b1;
        while ((sent < 6 || delivered - d0 < 6) && cyc < 200) begin
            out_ready = (cyc % 3 == 0);
            in_valid  = (sent < 6);
            if (in_valid && need_new) randomize_beat();
            step();
            need_new = acc;
            if (acc) sent++;
            cyc++;
        end
        in_valid = 1'b0;
        check("bp_delivered", delivered - d0, 6);
        check("bp_beat_cnt", beat_cnt, tb_cnt);

        // Random traffic with a beat held until it is accepted.
        need_new = 1'b1;
        for (int i = 0; i < 400; i++) begin
            out_ready = ($urandom_range(99) < 60);
            if (need_new) begin
                in_valid = ($urandom_range(99) < 70);
                if (in_valid) randomize_beat();
            end
            step();
            need_new = !in_valid || acc;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        cyc = 0;
        while (q.size() > 0 && cyc < 20) begin
            step();
            cyc++;
        end
        check("drain_empty", q.size(), 0);
        check("drain_out_valid", out_valid, 0);
        check("rand_beat_cnt", beat_cnt, tb_cnt);

        // Reset with two beats in flight.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        randomize_beat();
        step();
        check("mid_accept0", acc, 1);
        randomize_beat();
        step();
        check("mid_accept1", acc, 1);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_beat_cnt", beat_cnt, 0);
        check("mid_rst_in_ready", in_ready, 0);
        check("mid_rst_result", result, 0);
        q.delete();
        tb_cnt = '0; last_res = '0; last_sat = '0;
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        check("post_rst_in_ready", in_ready, 1);
        for (int i = 0; i < 5; i++) begin
            check("no_stale_beat", out_valid, 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
